// File: rtl/oib_target.sv
// rtl/oib_target.sv - outbound-bus frame target bridging byte frames to a memory request port
module oib_target #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ob_data,
    input  logic        ob_pty,
    output logic [7:0]  ib_data,
    output logic        ib_pty,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        parity_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_REQ,
        S_RESP
    } state_t;

    // Timeout fires on the edge where the count would reach TIMEOUT_CYCLES,
    // so mem_req stays high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] HDR_WRITE  = 8'h01;
    localparam logic [7:0] HDR_READ   = 8'h02;
    localparam logic [7:0] RSP_WRITE  = 8'h81;
    localparam logic [7:0] RSP_READ   = 8'h82;
    localparam logic [7:0] RSP_TMO    = 8'hFD;
    localparam logic [7:0] RSP_BADOP  = 8'hFE;
    localparam logic [7:0] RSP_PARITY = 8'hFF;

    state_t      state_q;
    logic [1:0]  bcnt_q;
    logic [15:0] tcnt_q;
    logic [2:0]  rcnt_q;
    logic [31:0] rdata_q;
    logic [7:0]  ib_data_q;
    logic        ib_pty_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        perr_q;
    logic        rdy_q;
    logic        ob_good;

    // Odd parity across the byte and its parity bit.
    assign ob_good = ^{ob_pty, ob_data};

    // Reset release is synchronized: the FSM only advances once this flop is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Frame decode, memory request handshake and response sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bcnt_q      <= 2'd0;
            tcnt_q      <= 16'd0;
            rcnt_q      <= 3'd0;
            rdata_q     <= 32'd0;
            ib_data_q   <= 8'h00;
            ib_pty_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            perr_q      <= 1'b0;
        end else if (rdy_q) begin
            perr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!ob_good) begin
                        perr_q    <= 1'b1;
                        ib_data_q <= RSP_PARITY;
                        ib_pty_q  <= ~^RSP_PARITY;
                        rcnt_q    <= 3'd0;
                        state_q   <= S_RESP;
                    end else if (ob_data == HDR_WRITE || ob_data == HDR_READ) begin
                        mem_we_q <= (ob_data == HDR_WRITE);
                        bcnt_q   <= 2'd0;
                        state_q  <= S_ADDR;
                    end else if (ob_data != 8'h00) begin
                        ib_data_q <= RSP_BADOP;
                        ib_pty_q  <= ~^RSP_BADOP;
                        rcnt_q    <= 3'd0;
                        state_q   <= S_RESP;
                    end
                end
                S_ADDR: begin
                    if (!ob_good) begin
                        perr_q    <= 1'b1;
                        ib_data_q <= RSP_PARITY;
                        ib_pty_q  <= ~^RSP_PARITY;
                        rcnt_q    <= 3'd0;
                        state_q   <= S_RESP;
                    end else begin
                        mem_addr_q <= {ob_data, mem_addr_q[31:8]};
                        bcnt_q     <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            if (mem_we_q) begin
                                state_q <= S_WDATA;
                            end else begin
                                mem_req_q <= 1'b1;
                                tcnt_q    <= 16'd0;
                                state_q   <= S_REQ;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (!ob_good) begin
                        perr_q    <= 1'b1;
                        ib_data_q <= RSP_PARITY;
                        ib_pty_q  <= ~^RSP_PARITY;
                        rcnt_q    <= 3'd0;
                        state_q   <= S_RESP;
                    end else begin
                        mem_wdata_q <= {ob_data, mem_wdata_q[31:8]};
                        bcnt_q      <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            mem_req_q <= 1'b1;
                            tcnt_q    <= 16'd0;
                            state_q   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_RESP;
                        if (mem_we_q) begin
                            ib_data_q <= RSP_WRITE;
                            ib_pty_q  <= ~^RSP_WRITE;
                            rcnt_q    <= 3'd0;
                        end else begin
                            ib_data_q <= RSP_READ;
                            ib_pty_q  <= ~^RSP_READ;
                            rdata_q   <= mem_rdata;
                            rcnt_q    <= 3'd4;
                        end
                    end else if (tcnt_q == TO_LAST) begin
                        mem_req_q <= 1'b0;
                        ib_data_q <= RSP_TMO;
                        ib_pty_q  <= ~^RSP_TMO;
                        rcnt_q    <= 3'd0;
                        state_q   <= S_RESP;
                    end else begin
                        tcnt_q <= tcnt_q + 16'd1;
                    end
                end
                S_RESP: begin
                    if (rcnt_q != 3'd0) begin
                        ib_data_q <= rdata_q[7:0];
                        ib_pty_q  <= ~^rdata_q[7:0];
                        rdata_q   <= {8'h00, rdata_q[31:8]};
                        rcnt_q    <= rcnt_q - 3'd1;
                    end else begin
                        ib_data_q <= 8'h00;
                        ib_pty_q  <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ib_data    = ib_data_q;
    assign ib_pty     = ib_pty_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_oib_target.sv
// tb/tb_oib_target.sv - directed self-checking bench for oib_target
module tb_oib_target;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ob_data;
    logic        ob_pty;
    logic [7:0]  ib_data;
    logic        ib_pty;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    oib_target #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ob_data    (ob_data),
        .ob_pty     (ob_pty),
        .ib_data    (ib_data),
        .ib_pty     (ib_pty),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ob_idle();
        ob_data = 8'h00;
        ob_pty  = 1'b1;
    endtask

    // Drive one byte for the next edge; good selects correct odd parity.
    task automatic send(input logic [7:0] b, input bit good);
        ob_data = b;
        ob_pty  = good ? ~^b : ^b;
        tick();
    endtask

    task automatic send_hdr_addr(input logic [7:0] hdr, input logic [31:0] a);
        send(hdr, 1'b1);
        send(a[7:0], 1'b1);
        send(a[15:8], 1'b1);
        send(a[23:16], 1'b1);
        send(a[31:24], 1'b1);
    endtask

    logic [7:0] exp_b [4];
    logic       exp_p [4];
    int         high_cnt;

    initial begin
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        ob_idle();
        #12;
        check("rst_ib_data", ib_data, 8'h00);
        check("rst_ib_pty", ib_pty, 1'b1);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_parity_err", parity_err, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Write 0xDEADBEEF to 0x00001000, ack after 3 cycles.
        send_hdr_addr(8'h01, 32'h0000_1000);
        check("wr_no_req_after_addr", mem_req, 1'b0);
        send(8'hEF, 1'b1);
        send(8'hBE, 1'b1);
        send(8'hAD, 1'b1);
        send(8'hDE, 1'b1);
        ob_idle();
        check("wr_req", mem_req, 1'b1);
        check("wr_we", mem_we, 1'b1);
        check("wr_addr", mem_addr, 32'h0000_1000);
        check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        tick();
        check("wr_req_held", mem_req, 1'b1);
        check("wr_addr_held", mem_addr, 32'h0000_1000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wr_req_drop", mem_req, 1'b0);
        check("wr_rsp", ib_data, 8'h81);
        check("wr_rsp_pty", ib_pty, 1'b1);
        tick();
        check("wr_idle", ib_data, 8'h00);
        check("wr_idle_pty", ib_pty, 1'b1);

        // Read from 0x20 returning 0x12345678.
        send_hdr_addr(8'h02, 32'h0000_0020);
        ob_idle();
        check("rd_req", mem_req, 1'b1);
        check("rd_we", mem_we, 1'b0);
        check("rd_addr", mem_addr, 32'h0000_0020);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        check("rd_req_drop", mem_req, 1'b0);
        check("rd_rsp", ib_data, 8'h82);
        check("rd_rsp_pty", ib_pty, 1'b1);
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
        exp_p = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rd_byte%0d", i), ib_data, exp_b[i]);
            check($sformatf("rd_pty%0d", i), ib_pty, exp_p[i]);
        end
        tick();
        check("rd_idle", ib_data, 8'h00);

        // Parity error on second address byte.
        send(8'h01, 1'b1);
        send(8'h04, 1'b1);
        send(8'h00, 1'b0);
        ob_idle();
        check("pe_pulse", parity_err, 1'b1);
        check("pe_rsp", ib_data, 8'hFF);
        check("pe_rsp_pty", ib_pty, 1'b1);
        check("pe_no_req", mem_req, 1'b0);
        tick();
        check("pe_pulse_end", parity_err, 1'b0);
        check("pe_idle", ib_data, 8'h00);
        check("pe_no_req2", mem_req, 1'b0);

        // Recovery write after the parity error.
        send_hdr_addr(8'h01, 32'h0000_0004);
        send(8'hA5, 1'b1);
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        ob_idle();
        check("rc_req", mem_req, 1'b1);
        check("rc_addr", mem_addr, 32'h0000_0004);
        check("rc_wdata", mem_wdata, 32'h0000_00A5);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rc_rsp", ib_data, 8'h81);
        tick();

        // Bad opcode.
        send(8'h7E, 1'b1);
        ob_idle();
        check("bo_rsp", ib_data, 8'hFE);
        check("bo_rsp_pty", ib_pty, 1'b0);
        check("bo_no_req", mem_req, 1'b0);
        check("bo_no_perr", parity_err, 1'b0);
        tick();
        check("bo_idle", ib_data, 8'h00);

        // Timeout: no ack, mem_req high for exactly 4 cycles.
        send_hdr_addr(8'h02, 32'h0000_0030);
        ob_idle();
        high_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== 1'b1) break;
            high_cnt++;
            tick();
        end
        check("to_req_cycles", high_cnt, 4);
        check("to_rsp", ib_data, 8'hFD);
        check("to_rsp_pty", ib_pty, 1'b0);
        tick();
        check("to_idle", ib_data, 8'h00);

        // Ack on the 4th cycle wins over the timeout.
        send_hdr_addr(8'h02, 32'h0000_0034);
        ob_idle();
        tick();
        tick();
        tick();
        check("ta_req_still", mem_req, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hA1B2_C3D4;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        check("ta_rsp", ib_data, 8'h82);
        check("ta_req_drop", mem_req, 1'b0);
        tick();
        check("ta_byte0", ib_data, 8'hD4);
        check("ta_pty0", ib_pty, 1'b1);
        tick();
        tick();
        tick();
        tick();
        check("ta_idle", ib_data, 8'h00);

        // Reset during REQ: mem_req drops at once, nothing emitted afterwards.
        send_hdr_addr(8'h02, 32'h0000_0040);
        ob_idle();
        check("rr_req", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rr_req_async_drop", mem_req, 1'b0);
        #1 rst_n = 1'b1;
        high_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            if (ib_data !== 8'h00 || mem_req !== 1'b0) high_cnt++;
        end
        check("rr_no_rsp", high_cnt, 0);

        // First frame after a fresh release is accepted on the second edge.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        send_hdr_addr(8'h02, 32'h0000_0050);
        ob_idle();
        check("rs_req", mem_req, 1'b1);
        check("rs_addr", mem_addr, 32'h0000_0050);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0011;
        tick();
        mem_ack = 1'b0;
        check("rs_rsp", ib_data, 8'h82);
        tick();
        check("rs_byte0", ib_data, 8'h11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oib_target.md
OIB_TARGET -- requirements
Module: oib_target

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum cycles mem_req stays high awaiting mem_ack (range 1..65535).
REQ-002 clk  in  1  sole clock; same edge as the outbound bus clock oib_clk.
REQ-003 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 ob_data  in  8  outbound byte from the core.
REQ-005 ob_pty  in  1  odd parity for ob_data.
REQ-006 ib_data  out  8  inbound response byte to the core.
REQ-007 ib_pty  out  1  odd parity for ib_data.
REQ-008 mem_req  out  1  memory-side request, level, held until ack or timeout.
REQ-009 mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-010 mem_addr  out  32  request address; valid while mem_req.
REQ-011 mem_wdata  out  32  write data; valid while mem_req and mem_we.
REQ-012 mem_ack  in  1  memory-side completion, single-cycle.
REQ-013 mem_rdata  in  32  read data; valid when mem_ack is high and mem_we is 0.
REQ-014 parity_err  out  1  one-cycle pulse per detected ob parity error.

Function
REQ-015 Odd parity: a sampled ob byte is good iff ^{ob_pty,ob_data} == 1; ib_pty shall equal ~^ib_data on every cycle.
REQ-016 Idle encoding on both directions: byte 0x00, parity 1.
REQ-017 Frame: header, 4 address bytes LSB-first, then 4 write-data bytes LSB-first for writes only; one byte per clk, no gaps.
REQ-018 Headers: 0x01 = write, 0x02 = read; any other nonzero good-parity header in IDLE is a bad opcode.
REQ-019 States: IDLE, ADDR, WDATA, REQ, RESP.
REQ-020 IDLE: 0x00 with good parity -> stay; 0x01/0x02 -> ADDR, byte count 0; bad opcode -> RESP with response 0xFE; bad parity (any byte) -> RESP with 0xFF.
REQ-021 ADDR: after the 4th byte -> WDATA (write) or REQ (read); WDATA: after the 4th byte -> REQ.
REQ-022 Parity error in ADDR or WDATA: abort frame, parity_err pulse, -> RESP with 0xFF; no memory request issued.
REQ-023 mem_req shall rise the cycle after the last frame byte is sampled, with mem_addr/mem_we/mem_wdata stable for its duration.
REQ-024 REQ: mem_ack sampled high -> mem_req low next cycle, -> RESP with 0x81 (write) or 0x82 followed by mem_rdata captured at ack, LSB-first.
REQ-025 Timeout: counter increments each cycle in REQ; on reaching TIMEOUT_CYCLES without ack, drop mem_req, -> RESP with 0xFD; ack and timeout in the same cycle -> ack wins.
REQ-026 Ack latency: first response byte on ib_data the cycle after mem_ack sampled; read bytes on the following 4 consecutive cycles; then ib idle, -> IDLE.
REQ-027 Bytes on ob while in REQ or RESP are ignored, parity not checked, parity_err not pulsed.
REQ-028 mem_ack while mem_req low is ignored.
REQ-029 ib_data/ib_pty, mem_* and parity_err are registered outputs.

Reset
REQ-030 rst_n low asynchronously forces IDLE, ib_data=0x00, ib_pty=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, parity_err=0, counters 0.
REQ-031 Reset mid-frame or mid-request discards the transaction; after release no response is emitted for it.
REQ-032 Release of rst_n is synchronized internally; first frame accepted on the second clk after release.

Verification
REQ-033 Write 0x01, addr 0x00001000, data 0xDEADBEEF -> mem_req/mem_we=1, mem_addr=0x00001000, mem_wdata=0xDEADBEEF; ack after 3 cycles -> ib 0x81 then 0x00.
REQ-034 Read 0x02, addr 0x20 with mem_rdata=0x12345678 at ack -> ib sequence 0x82,0x78,0x56,0x34,0x12 with correct odd parity each cycle.
REQ-035 Flip ob_pty on 2nd address byte -> parity_err pulse once, no mem_req, ib 0xFF, subsequent valid frame completes normally.
REQ-036 TIMEOUT_CYCLES=4, read with no ack -> mem_req high exactly 4 cycles, ib 0xFD; ack on 4th cycle instead -> 0x82 response.
REQ-037 Header 0x7E -> ib 0xFE, no mem_req; rst_n low during REQ -> mem_req drops immediately, no response after release.
